// File: rtl/exp_pkg.sv
// Shared definitions for the exponent-engine dispatcher: default sizes and FSM state encoding.
// Latency/backpressure: n/a (types and constants only).
package exp_pkg;

    localparam int DEF_WIDTH   = 16;
    localparam int DEF_DEPTH   = 4;
    localparam int DEF_TIMEOUT = 32;

    // Engine state register needs this many WAIT cycles before eng_done is trustworthy.
    localparam int ENG_BLIND = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_RESP  = 3'd3,
        ST_CLR   = 3'd4
    } state_t;

endpackage

// File: rtl/exp_dispatch_if.sv
// Request, engine and result handshakes of the dispatcher; master = dispatcher, slave = environment.
// Latency/backpressure: wiring only; valid/ready on request and result, start/done/clr on engine.
interface exp_dispatch_if import exp_pkg::*; #(parameter int WIDTH = DEF_WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_c;
    logic [WIDTH-1:0] in_j;

    logic             eng_start;
    logic [WIDTH-1:0] eng_c;
    logic [WIDTH-1:0] eng_j;
    logic             eng_done;
    logic [WIDTH-1:0] eng_g;
    logic             eng_clr;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_g;
    logic             out_err;

    modport master (
        input  in_valid, in_c, in_j, eng_done, eng_g, out_ready,
        output in_ready, eng_start, eng_c, eng_j, eng_clr, out_valid, out_g, out_err
    );

    modport slave (
        output in_valid, in_c, in_j, eng_done, eng_g, out_ready,
        input  in_ready, eng_start, eng_c, eng_j, eng_clr, out_valid, out_g, out_err
    );

endinterface

// File: rtl/exp_req_fifo.sv
// DEPTH-entry synchronous request FIFO, head visible combinationally on rdata.
// Latency: 1 cycle push-to-nonempty; a push while full is taken only together with a pop.
module exp_req_fifo import exp_pkg::*; #(
    parameter int DW    = 2 * DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] wdata,
    input  logic          pop,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]   wptr;
    logic [AW:0]   rptr;
    logic [DW-1:0] mem [DEPTH];
    logic          do_push;
    logic          do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + (AW+1)'(1);
            if (do_pop)  rptr <= rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/exp_dispatch.sv
// Queues (c, j) requests, screens operands, runs one engine job at a time with a timeout, returns g or error.
// Latency: error result 2 cycles after accept, out_valid 1 cycle after eng_done; in_ready drops when FIFO full.
module exp_dispatch import exp_pkg::*; #(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic            clk,
    input  logic            rst,
    exp_dispatch_if.master  bus
);

    localparam int             TW     = $clog2(TIMEOUT) + 1;
    localparam logic [TW-1:0]  T_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0]  T_OPEN = TW'(ENG_BLIND + 1);

    state_t             state;
    logic [TW-1:0]      timer;
    logic               rdy_q;
    logic               start_q;
    logic               clr_q;
    logic [WIDTH-1:0]   eng_c_q;
    logic [WIDTH-1:0]   eng_j_q;
    logic               out_valid_q;
    logic [WIDTH-1:0]   out_g_q;
    logic               out_err_q;

    logic               full;
    logic               empty;
    logic               push;
    logic               pop;
    logic [2*WIDTH-1:0] head;
    logic [WIDTH-1:0]   head_c;
    logic [WIDTH-1:0]   head_j;

    assign bus.in_ready  = rdy_q && !full;
    assign bus.eng_start = start_q;
    assign bus.eng_c     = eng_c_q;
    assign bus.eng_j     = eng_j_q;
    assign bus.eng_clr   = clr_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_g     = out_g_q;
    assign bus.out_err   = out_err_q;

    assign push   = bus.in_valid && bus.in_ready;
    assign pop    = (state == ST_IDLE) && !empty;
    assign head_c = head[2*WIDTH-1:WIDTH];
    assign head_j = head[WIDTH-1:0];

    exp_req_fifo #(.DW(2*WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata ({bus.in_c, bus.in_j}),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            timer       <= '0;
            rdy_q       <= 1'b0;
            start_q     <= 1'b0;
            clr_q       <= 1'b1;
            eng_c_q     <= '0;
            eng_j_q     <= '0;
            out_valid_q <= 1'b0;
            out_g_q     <= '0;
            out_err_q   <= 1'b0;
        end else begin
            rdy_q   <= 1'b1;
            start_q <= 1'b0;
            clr_q   <= 1'b0;
            // Timer is cleared on issue, so it reads 0 during the eng_start cycle.
            if (timer != '1) timer <= timer + TW'(1);

            case (state)
                ST_IDLE: begin
                    if (!empty) begin
                        if (head_c < WIDTH'(2) || head_j == '0) begin
                            out_g_q     <= '0;
                            out_err_q   <= 1'b1;
                            out_valid_q <= 1'b1;
                            state       <= ST_RESP;
                        end else begin
                            eng_c_q <= head_c;
                            eng_j_q <= head_j;
                            start_q <= 1'b1;
                            timer   <= '0;
                            state   <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: state <= ST_WAIT;
                ST_WAIT: begin
                    if (timer >= T_OPEN && bus.eng_done) begin
                        out_g_q     <= bus.eng_g;
                        out_err_q   <= 1'b0;
                        out_valid_q <= 1'b1;
                        state       <= ST_RESP;
                    end else if (timer == T_LAST) begin
                        out_g_q     <= '0;
                        out_err_q   <= 1'b1;
                        out_valid_q <= 1'b1;
                        state       <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        clr_q       <= 1'b1;
                        state       <= ST_CLR;
                    end
                end
                ST_CLR:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exp_dispatch.sv
// Directed bench for exp_dispatch with a behavioural exponent engine (fixed latency or hung).
module tb_exp_dispatch;
    import exp_pkg::*;

    logic clk;
    logic rst;

    exp_dispatch_if #(.WIDTH(16)) bus ();

    exp_dispatch #(.WIDTH(16), .DEPTH(4), .TIMEOUT(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    int cyc       = 0;
    int n_start   = 0;
    int n_clr     = 0;
    int start_cyc = 0;
    int valid_cyc = 0;
    bit hang      = 1'b0;
    logic [16:0] res_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic logic [15:0] eng_result(input logic [15:0] c, input logic [15:0] j);
        logic [63:0] p;
        int g;
        p = 64'(c);
        g = 0;
        while (p < 64'(j) && g < 64) begin
            p = p * 64'(c);
            g++;
        end
        return 16'(g);
    endfunction

    // Monitor and engine model, evaluated just after each falling edge.
    initial begin
        int   eng_cnt;
        bit   eng_busy;
        logic prev_valid;
        bus.eng_done = 1'b0;
        bus.eng_g    = '0;
        eng_cnt      = 0;
        eng_busy     = 1'b0;
        prev_valid   = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            cyc++;
            if (bus.eng_start === 1'b1) begin
                n_start++;
                start_cyc = cyc;
            end
            if (bus.eng_clr === 1'b1) n_clr++;
            if (bus.out_valid === 1'b1 && prev_valid !== 1'b1) valid_cyc = cyc;
            prev_valid = bus.out_valid;
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1)
                res_q.push_back({bus.out_err, bus.out_g});
            if (bus.eng_clr === 1'b1) begin
                bus.eng_done = 1'b0;
                bus.eng_g    = '0;
                eng_busy     = 1'b0;
            end else if (bus.eng_start === 1'b1) begin
                eng_busy = 1'b1;
                eng_cnt  = 3;
            end else if (eng_busy && !hang && bus.eng_done == 1'b0) begin
                if (eng_cnt == 0) begin
                    bus.eng_done = 1'b1;
                    bus.eng_g    = eng_result(bus.eng_c, bus.eng_j);
                end else begin
                    eng_cnt--;
                end
            end
        end
    end

    task automatic sample();
        @(negedge clk);
        #2;
    endtask

    task automatic push(input logic [15:0] c, input logic [15:0] j);
        int w;
        w = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_c     = c;
        bus.in_j     = j;
        #1;
        while (bus.in_ready !== 1'b1 && w < 200) begin
            @(negedge clk);
            #1;
            w++;
        end
        chk("push_accept", 32'(bus.in_ready), 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic get_res(input string tag, input logic exp_err, input logic [15:0] exp_g);
        int w;
        logic [16:0] r;
        w = 0;
        while (res_q.size() == 0 && w < 400) begin
            @(negedge clk);
            w++;
        end
        chk({tag, "_avail"}, 32'(res_q.size() > 0), 1);
        if (res_q.size() > 0) begin
            r = res_q.pop_front();
            chk({tag, "_err"}, 32'(r[16]), 32'(exp_err));
            chk({tag, "_g"}, 32'(r[15:0]), 32'(exp_g));
        end
    endtask

    initial begin
        int s0;
        int c0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_c      = '0;
        bus.in_j      = '0;
        bus.out_ready = 1'b1;

        // Reset values
        repeat (3) @(negedge clk);
        #2;
        chk("rst_in_ready", 32'(bus.in_ready), 0);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_eng_clr", 32'(bus.eng_clr), 1);
        chk("rst_eng_start", 32'(bus.eng_start), 0);
        @(negedge clk);
        rst = 1'b0;
        sample();
        chk("post_rst_in_ready", 32'(bus.in_ready), 1);
        chk("post_rst_eng_clr", 32'(bus.eng_clr), 0);

        // 1: single legal job
        s0 = n_start;
        c0 = n_clr;
        push(16'd2, 16'd100);
        get_res("t1", 1'b0, 16'd6);
        chk("t1_starts", 32'(n_start - s0), 1);
        chk("t1_done_to_valid", 32'(valid_cyc - start_cyc), 5);
        repeat (3) @(negedge clk);
        chk("t1_clrs", 32'(n_clr - c0), 1);

        // 2: back-to-back jobs, ordered
        s0 = n_start;
        c0 = n_clr;
        push(16'd3, 16'd10);
        push(16'd5, 16'd3);
        get_res("t2a", 1'b0, 16'd2);
        get_res("t2b", 1'b0, 16'd0);
        repeat (3) @(negedge clk);
        chk("t2_starts", 32'(n_start - s0), 2);
        chk("t2_clrs", 32'(n_clr - c0), 2);

        // 3: illegal operands bypass the engine
        s0 = n_start;
        c0 = n_clr;
        push(16'd1, 16'd50);
        push(16'd0, 16'd7);
        get_res("t3a", 1'b1, 16'd0);
        get_res("t3b", 1'b1, 16'd0);
        repeat (3) @(negedge clk);
        chk("t3_starts", 32'(n_start - s0), 0);
        chk("t3_clrs", 32'(n_clr - c0), 2);

        // 4: hung engine -> timeout
        hang = 1'b1;
        c0 = n_clr;
        push(16'd2, 16'd65535);
        get_res("t4", 1'b1, 16'd0);
        chk("t4_timeout_cycles", 32'(valid_cyc - start_cyc), 32);
        repeat (3) @(negedge clk);
        chk("t4_clrs", 32'(n_clr - c0), 1);
        hang = 1'b0;

        // 5: backpressure fills the FIFO behind the active job
        @(negedge clk);
        bus.out_ready = 1'b0;
        push(16'd2, 16'd100);
        repeat (10) @(negedge clk);
        push(16'd2, 16'd3);
        push(16'd4, 16'd65);
        push(16'd2, 16'd2048);
        push(16'd1, 16'd5);
        sample();
        chk("t5_full_in_ready", 32'(bus.in_ready), 0);
        chk("t5_held_valid", 32'(bus.out_valid), 1);
        @(negedge clk);
        bus.out_ready = 1'b1;
        get_res("t5a", 1'b0, 16'd6);
        get_res("t5b", 1'b0, 16'd1);
        get_res("t5c", 1'b0, 16'd3);
        get_res("t5d", 1'b0, 16'd10);
        get_res("t5e", 1'b1, 16'd0);

        // 6: reset during WAIT with two requests queued
        hang = 1'b1;
        s0 = n_start;
        push(16'd2, 16'd100);
        push(16'd3, 16'd10);
        push(16'd5, 16'd3);
        repeat (2) @(negedge clk);
        chk("t6_one_start", 32'(n_start - s0), 1);
        @(negedge clk);
        rst = 1'b1;
        sample();
        chk("t6_in_ready", 32'(bus.in_ready), 0);
        chk("t6_out_valid", 32'(bus.out_valid), 0);
        chk("t6_eng_clr", 32'(bus.eng_clr), 1);
        @(negedge clk);
        rst  = 1'b0;
        hang = 1'b0;
        res_q.delete();
        repeat (40) @(negedge clk);
        chk("t6_no_stale", 32'(res_q.size()), 0);
        chk("t6_idle_valid", 32'(bus.out_valid), 0);
        push(16'd2, 16'd8);
        get_res("t6_new", 1'b0, 16'd2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", n_pass, n_chk);
        $fatal(1);
    end

endmodule
